// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared multiplier constants, ALU select codes and state encodings
package mul_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // ALU select codes for the HI/LO multiply ops (funct field values)
  localparam logic [5:0] MULT_OP  = 6'h18;
  localparam logic [5:0] MULTU_OP = 6'h19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic is_mul_op(input logic [5:0] funct);
    return (funct == MULT_OP) || (funct == MULTU_OP);
  endfunction

endpackage

// File: rtl/mul_abs.sv
// rtl/mul_abs.sv - combinational conditional negate giving an operand magnitude
module mul_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             sign_en,
  output logic [WIDTH-1:0] magnitude
);

  // The most negative value maps to itself, which is its correct unsigned magnitude
  assign magnitude = (sign_en && value[WIDTH-1]) ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - radix-2 shift-add multiplier producing HI/LO with start/busy/done handshake
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc_hi;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_fix;

  mul_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value     (a),
    .sign_en   (is_signed),
    .magnitude (a_mag)
  );

  mul_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value     (b),
    .sign_en   (is_signed),
    .magnitude (b_mag)
  );

  // The multiplier register doubles as the low half of the accumulator as bits retire
  always_comb begin
    step_sum = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc      = {acc_hi, mplier};
    acc_fix  = neg ? (~acc + (2*WIDTH)'(1)) : acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc_hi <= '0;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            count  <= '0;
            busy   <= 1'b1;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            acc_hi <= step_sum[WIDTH:1];
            mplier <= {step_sum[0], mplier[WIDTH-1:1]};
            count  <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (!cancel) begin
            hi   <= acc_fix[2*WIDTH-1:WIDTH];
            lo   <= acc_fix[WIDTH-1:0];
            done <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq against an arithmetic product model
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_err;

  mul_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_product(input logic [31:0] x, input logic [31:0] y,
                                              input logic s);
    longint          sx;
    longint          sy;
    longint unsigned ux;
    longint unsigned uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return 64'(ux * uy);
  endfunction

  // Caller is at a negedge; returns at the negedge where done is seen (or after the budget)
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                       output logic [31:0] ohi, output logic [31:0] olo,
                       output int done_k, output int busy_cnt);
    a = ia; b = ib; is_signed = is; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
    done_k = -1; busy_cnt = 0; ohi = '0; olo = '0;
    for (int k = 0; k < 100; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_k = k; ohi = hi; olo = lo;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; cancel = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [31:0] rh, rl;
    int dk, bc;
    @(negedge clk);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, rh, rl, dk, bc);
    n_cmp++;
    if (dk !== 33 || bc !== 33) begin
      n_err++;
      $display("FAIL umax_timing: done_k=%0d busy_cycles=%0d, want 33/33", dk, bc);
    end
    n_cmp++;
    if ({rh, rl} !== 64'hFFFFFFFE_00000001) begin
      n_err++;
      $display("FAIL umax_result: got %h_%h, want fffffffe_00000001", rh, rl);
    end
    @(negedge clk);
    do_op(32'hFFFFFFFF, 32'h00000003, 1'b1, rh, rl, dk, bc);
    n_cmp++;
    if ({rh, rl} !== 64'hFFFFFFFF_FFFFFFFD) begin
      n_err++;
      $display("FAIL signed_mixed: got %h_%h, want ffffffff_fffffffd", rh, rl);
    end
    @(negedge clk);
    do_op(32'hFFFFFFFF, 32'h00000003, 1'b0, rh, rl, dk, bc);
    n_cmp++;
    if ({rh, rl} !== 64'h00000002_FFFFFFFD) begin
      n_err++;
      $display("FAIL unsigned_mixed: got %h_%h, want 00000002_fffffffd", rh, rl);
    end
    @(negedge clk);
    do_op(32'h80000000, 32'h80000000, 1'b1, rh, rl, dk, bc);
    n_cmp++;
    if ({rh, rl} !== 64'h40000000_00000000) begin
      n_err++;
      $display("FAIL signed_min_min: got %h_%h, want 40000000_00000000", rh, rl);
    end
    @(negedge clk);
    do_op(32'h00000000, 32'h12345678, 1'b1, rh, rl, dk, bc);
    n_cmp++;
    if (dk !== 33 || {rh, rl} !== 64'd0) begin
      n_err++;
      $display("FAIL zero_operand: done_k=%0d got %h_%h, want 33 and 0", dk, rh, rl);
    end
  endtask

  task automatic test_random;
    logic [31:0] ra, rb, rh, rl;
    logic        rs;
    logic [63:0] exp_p;
    int dk, bc;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'(i % 2);
      if (i == 2) ra = 32'h80000000;
      if (i == 3) rb = 32'h7FFFFFFF;
      exp_p = ref_product(ra, rb, rs);
      @(negedge clk);
      do_op(ra, rb, rs, rh, rl, dk, bc);
      n_cmp++;
      if (dk !== 33 || {rh, rl} !== exp_p) begin
        n_err++;
        $display("FAIL random_%0d: a=%h b=%h s=%b done_k=%0d got %h_%h, want 33 and %h",
                 i, ra, rb, rs, dk, rh, rl, exp_p);
      end
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({hi, lo} !== exp_p || done !== 1'b0) begin
      n_err++;
      $display("FAIL stale_hold: got %h_%h done=%b, want %h done=0", hi, lo, done, exp_p);
    end
  endtask

  task automatic test_start_during_busy;
    int dk;
    @(negedge clk);
    a = 32'd6; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dk = -1;
    for (int k = 6; k < 100; k++) begin
      if (done) begin
        dk = k;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (dk !== 33 || hi !== 32'd0 || lo !== 32'd42) begin
      n_err++;
      $display("FAIL start_in_busy: done_k=%0d got %h_%h, want 33 and 0_2a", dk, hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rh, rl;
    int dk, bc;
    @(negedge clk);
    do_op(32'd11, 32'd13, 1'b0, rh, rl, dk, bc);
    do_op(32'd2, 32'd3, 1'b0, rh, rl, dk, bc);
    n_cmp++;
    if (dk !== 33 || rh !== 32'd0 || rl !== 32'd6) begin
      n_err++;
      $display("FAIL back_to_back: done_k=%0d got %h_%h, want 33 and 0_6", dk, rh, rl);
    end
  endtask

  task automatic test_cancel;
    logic [31:0] rh, rl;
    int dk, bc;
    bit seen;
    @(negedge clk);
    do_op(32'h80000001, 32'd2, 1'b0, rh, rl, dk, bc);
    n_cmp++;
    if ({rh, rl} !== 64'h00000001_00000002) begin
      n_err++;
      $display("FAIL cancel_prior: got %h_%h, want 00000001_00000002", rh, rl);
    end
    @(negedge clk);
    a = 32'd4; b = 32'd4; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h1 || lo !== 32'h2) begin
      n_err++;
      $display("FAIL cancel_fix: done=%b busy=%b hi=%h lo=%h, want 0 0 1 2", done, busy, hi, lo);
    end
    @(negedge clk);
    a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0 || hi !== 32'h1 || lo !== 32'h2) begin
      n_err++;
      $display("FAIL cancel_busy: activity=%b hi=%h lo=%h, want 0 1 2", seen, hi, lo);
    end
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    @(negedge clk);
    a = 32'd5; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_async: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_done: activity after reset release=%b, want 0", seen);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_during_busy();
    test_back_to_back();
    test_cancel();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Multi-cycle radix-2 shift-add multiplier that writes the HI/LO pair for MULT/MULTU in the EX stage.
- Complements the divide path: divide consumes {a,b} into quotient/remainder; this block produces the 64-bit product into hi/lo.
- Start/busy/done handshake, so the pipeline controller stalls on busy and the mfhi/mflo path reads hi/lo after done.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits, split into hi (upper) and lo (lower).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; latched with start.
- a  in  WIDTH  multiplicand; latched with start.
- b  in  WIDTH  multiplier; latched with start.
- cancel  in  1  abort (pipeline flush); ignored in IDLE.
- busy  out  1  high while an operation is in flight; drives the EX stall.
- done  out  1  one-cycle pulse; hi/lo are valid in the same cycle.
- hi  out  WIDTH  product[2*WIDTH-1:WIDTH]; registered.
- lo  out  WIDTH  product[WIDTH-1:0]; registered.

Behaviour:
- Reset (rst=0, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; all internal registers cleared.
  - Takes effect immediately, without waiting for a clock edge.
- States: IDLE, BUSY, FIX.
- IDLE:
  - start=1 at edge E0 latches |a|, |b| (magnitudes when is_signed=1, raw values otherwise).
  - Also at E0: neg = is_signed & (a[MSB]^b[MSB]); count=0; acc=0; go to BUSY.
- BUSY, one bit per edge:
  - If mplier[0]=1, acc_hi += mcand (WIDTH+1-bit sum, carry kept).
  - Then {carry,acc_hi,mplier} shifts right by 1; count increments.
  - After WIDTH BUSY edges (E0+WIDTH) go to FIX.
- FIX, at edge E0+WIDTH+1:
  - {hi,lo} = neg ? -acc : acc, using 2*WIDTH-bit two's-complement negation.
  - done=1 for exactly the following cycle; state returns to IDLE.
- Latency: WIDTH+1 edges from the start edge to the result; done is visible in cycle E0+WIDTH+1. For WIDTH=32 that is 33 edges.
- busy=1 from after E0 through the FIX edge. busy=0 in the cycle where done=1.
- done is registered. It falls on the next edge unless it is retriggered.
- Operand magnitude: |0x80000000| is taken as unsigned 0x80000000; no overflow.
- No early termination. Zero operands still take the full latency.
- start while BUSY/FIX is ignored; no queueing.
- start in the done cycle (state is IDLE) is accepted. done and busy may then be high in adjacent cycles.
- cancel=1 in BUSY or FIX:
  - Next state is IDLE; hi/lo keep their previous values; done stays 0.
  - cancel beats the FIX write if both occur on the same edge.
- start and cancel together in IDLE: start wins (cancel is ignored in IDLE).
- hi/lo change only on a FIX edge or on reset. They hold indefinitely otherwise, so a stale read returns the last product.
- Input changes after E0 have no effect on the running operation.

Decomposition:
- Shared constants header, alongside the existing op-code defines:
  - mult_op and multu_op ALU select codes.
  - 2-bit state encodings: IDLE=0, BUSY=1, FIX=2.
- One sub-module, mul_abs: combinational WIDTH-bit conditional negate (value, sign_en → magnitude). Instantiated twice for operand conditioning.
- Final 2*WIDTH negate stays inline in FIX.

Test Plan:
- Reset mid-run: start a=5,b=7 unsigned, drop rst at cycle 10 → busy=0, hi=0, lo=0 immediately; no done after rst returns high.
- Unsigned max: a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0 → done in cycle E0+33, hi=0xFFFFFFFE, lo=0x00000001, busy high for exactly 33 cycles.
- Signed mixed: a=0xFFFFFFFF (-1), b=0x00000003, is_signed=1 → hi=0xFFFFFFFF, lo=0xFFFFFFFD. Same operands with is_signed=0 → hi=0x00000002, lo=0xFFFFFFFD.
- Signed min×min: a=b=0x80000000, is_signed=1 → hi=0x40000000, lo=0x00000000.
- Handshake corners:
  - start during BUSY with a=9 → ignored; result still from the original operands.
  - Back-to-back start in the done cycle (a=2,b=3) → accepted; second done 33 cycles later with lo=6.
- Cancel: prior result hi=0x1, lo=0x2; start a=4,b=4, cancel at FIX edge → IDLE, no done, hi=0x1, lo=0x2 unchanged.
